// File: rtl/mem_bus_arbiter_if.sv
// Bundle for the two requester ports and the memory_bus side of the arbiter.
//   req0/1, we0/1, addr0/1, wdata0/1, mask0/1 : requester payloads (to arbiter)
//   ack0/1, rdata, grant, busy                : requester responses (from arbiter)
//   mem_address, mem_write, mem_write_mask,
//   mem_bus_enable, mem_write_enable          : memory_bus drive (from arbiter)
//   mem_read                                  : memory_bus data_out (to arbiter)
// slave modport = arbiter view, master modport = requesters + memory view.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [31:0]           wdata0;
  logic [31:0]           wdata1;
  logic [3:0]            mask0;
  logic [3:0]            mask1;
  logic                  ack0;
  logic                  ack1;
  logic [31:0]           rdata;
  logic [1:0]            grant;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write;
  logic [3:0]            mem_write_mask;
  logic                  mem_bus_enable;
  logic                  mem_write_enable;
  logic [31:0]           mem_read;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
    input  mem_read,
    output ack0, ack1, rdata, grant, busy,
    output mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
    output mem_read,
    input  ack0, ack1, rdata, grant, busy,
    input  mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of memory_bus. Each access runs IDLE -> ISSUE ->
// DONE: bus enable for one cycle, read data captured the next cycle, then a
// one-cycle ack to the winner.
//   clk   : CPU clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_bus_arbiter_if.slave (requester ports + memory_bus side)
module mem_bus_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned ADDR_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // last_grant: 0 = port 0, 1 = port 1
  logic                  r_last_grant;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [31:0]           r_rdata;
  logic [1:0]            r_grant;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_write;
  logic [3:0]            r_mem_write_mask;
  logic                  r_mem_bus_enable;
  logic                  r_mem_write_enable;

  logic                  w_last_grant;
  logic                  w_ack0;
  logic                  w_ack1;
  logic [31:0]           w_rdata;
  logic [1:0]            w_grant;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_mem_address;
  logic [31:0]           w_mem_write;
  logic [3:0]            w_mem_write_mask;
  logic                  w_mem_bus_enable;
  logic                  w_mem_write_enable;

  logic                  w_req_any;
  logic                  w_winner;

  assign w_req_any = bus.req0 | bus.req1;

  // Winner select: single requester wins outright; on contention either
  // port 0 (fixed) or the port that did not win last time.
  always_comb begin
    w_winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      w_winner = FIXED_PRIORITY ? 1'b0 : ~r_last_grant;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output
  always_comb begin
    w_last_grant       = r_last_grant;
    w_ack0             = r_ack0;
    w_ack1             = r_ack1;
    w_rdata            = r_rdata;
    w_grant            = r_grant;
    w_busy             = r_busy;
    w_mem_address      = r_mem_address;
    w_mem_write        = r_mem_write;
    w_mem_write_mask   = r_mem_write_mask;
    w_mem_bus_enable   = r_mem_bus_enable;
    w_mem_write_enable = r_mem_write_enable;
    case (r_state)
      S_IDLE: begin
        w_mem_bus_enable   = 1'b0;
        w_mem_write_enable = 1'b0;
        if (w_req_any) begin
          w_mem_address      = w_winner ? bus.addr1  : bus.addr0;
          w_mem_write        = w_winner ? bus.wdata1 : bus.wdata0;
          w_mem_write_mask   = w_winner ? bus.mask1  : bus.mask0;
          w_mem_write_enable = w_winner ? bus.we1    : bus.we0;
          w_mem_bus_enable   = 1'b1;
          w_grant            = w_winner ? 2'b10 : 2'b01;
          w_last_grant       = w_winner;
          w_busy             = 1'b1;
        end
      end
      S_ISSUE: begin
        // memory_bus data_out is valid the cycle after the enable
        w_mem_bus_enable   = 1'b0;
        w_mem_write_enable = 1'b0;
        w_rdata            = bus.mem_read;
        w_ack0             = r_grant[0];
        w_ack1             = r_grant[1];
      end
      S_DONE: begin
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_grant = 2'b00;
        w_busy  = 1'b0;
      end
      default: begin
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_grant = 2'b00;
        w_busy  = 1'b0;
      end
    endcase
  end

  // Output registers; last_grant resets to port 1 so port 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant       <= 1'b1;
      r_ack0             <= 1'b0;
      r_ack1             <= 1'b0;
      r_rdata            <= 32'h0;
      r_grant            <= 2'b00;
      r_busy             <= 1'b0;
      r_mem_address      <= '0;
      r_mem_write        <= 32'h0;
      r_mem_write_mask   <= 4'h0;
      r_mem_bus_enable   <= 1'b0;
      r_mem_write_enable <= 1'b0;
    end else begin
      r_last_grant       <= w_last_grant;
      r_ack0             <= w_ack0;
      r_ack1             <= w_ack1;
      r_rdata            <= w_rdata;
      r_grant            <= w_grant;
      r_busy             <= w_busy;
      r_mem_address      <= w_mem_address;
      r_mem_write        <= w_mem_write;
      r_mem_write_mask   <= w_mem_write_mask;
      r_mem_bus_enable   <= w_mem_bus_enable;
      r_mem_write_enable <= w_mem_write_enable;
    end
  end

  assign bus.ack0             = r_ack0;
  assign bus.ack1             = r_ack1;
  assign bus.rdata            = r_rdata;
  assign bus.grant            = r_grant;
  assign bus.busy             = r_busy;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_write        = r_mem_write;
  assign bus.mem_write_mask   = r_mem_write_mask;
  assign bus.mem_bus_enable   = r_mem_bus_enable;
  assign bus.mem_write_enable = r_mem_write_enable;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks, monitors pop on each ack.
module tb_mem_bus_arbiter;

  typedef struct {
    logic        port;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   acks_rr;
  int   acks_fp;
  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t e_rr;
  exp_t e_fp;

  mem_bus_arbiter_if #(.ADDR_WIDTH(16)) ifa ();
  mem_bus_arbiter_if #(.ADDR_WIDTH(16)) ifp ();

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b0), .ADDR_WIDTH(16)) dut_rr (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa.slave)
  );

  mem_bus_arbiter #(.FIXED_PRIORITY(1'b1), .ADDR_WIDTH(16)) dut_fp (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifp.slave)
  );

  // Simple memory: fixed instruction word at 0x4000, address pattern elsewhere
  function automatic logic [31:0] mem_model(input logic [15:0] a);
    return (a == 16'h4000) ? 32'h00c0_0093 : {~a, a};
  endfunction

  assign ifa.mem_read = mem_model(ifa.mem_address);
  assign ifp.mem_read = mem_model(ifp.mem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: round-robin instance
  always @(negedge clk) begin
    if (ifa.ack0 || ifa.ack1) begin
      acks_rr++;
      if (q_rr.size() == 0) begin
        chk("rr_unexpected_ack", 32'({ifa.ack1, ifa.ack0}), 32'd0);
      end else begin
        e_rr = q_rr.pop_front();
        chk("rr_ack_port", 32'({ifa.ack1, ifa.ack0}), e_rr.port ? 32'd2 : 32'd1);
        chk("rr_grant_at_ack", 32'(ifa.grant), e_rr.port ? 32'd2 : 32'd1);
        if (e_rr.chk_rd) chk("rr_rdata", ifa.rdata, e_rr.rdata);
      end
    end
  end

  // Monitor: fixed-priority instance
  always @(negedge clk) begin
    if (ifp.ack0 || ifp.ack1) begin
      acks_fp++;
      if (q_fp.size() == 0) begin
        chk("fp_unexpected_ack", 32'({ifp.ack1, ifp.ack0}), 32'd0);
      end else begin
        e_fp = q_fp.pop_front();
        chk("fp_ack_port", 32'({ifp.ack1, ifp.ack0}), e_fp.port ? 32'd2 : 32'd1);
        if (e_fp.chk_rd) chk("fp_rdata", ifp.rdata, e_fp.rdata);
      end
    end
  end

  function automatic logic rr_outs_any();
    return |{ifa.ack0, ifa.ack1, ifa.rdata, ifa.grant, ifa.busy, ifa.mem_address,
             ifa.mem_write, ifa.mem_write_mask, ifa.mem_bus_enable, ifa.mem_write_enable};
  endfunction

  function automatic logic fp_outs_any();
    return |{ifp.ack0, ifp.ack1, ifp.rdata, ifp.grant, ifp.busy, ifp.mem_address,
             ifp.mem_write, ifp.mem_write_mask, ifp.mem_bus_enable, ifp.mem_write_enable};
  endfunction

  // Single uncontended access on the round-robin instance with bus checks
  task automatic access(input logic port, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] mk);
    exp_t e;
    @(negedge clk);
    if (port) begin
      ifa.we1 = we; ifa.addr1 = addr; ifa.wdata1 = wd; ifa.mask1 = mk; ifa.req1 = 1'b1;
    end else begin
      ifa.we0 = we; ifa.addr0 = addr; ifa.wdata0 = wd; ifa.mask0 = mk; ifa.req0 = 1'b1;
    end
    e.port = port; e.chk_rd = ~we; e.rdata = mem_model(addr);
    q_rr.push_back(e);
    @(negedge clk);
    chk("issue_bus_enable", 32'(ifa.mem_bus_enable), 32'd1);
    chk("issue_write_enable", 32'(ifa.mem_write_enable), 32'(we));
    chk("issue_address", 32'(ifa.mem_address), 32'(addr));
    chk("issue_wdata", ifa.mem_write, wd);
    chk("issue_mask", 32'(ifa.mem_write_mask), 32'(mk));
    chk("issue_grant", 32'(ifa.grant), port ? 32'd2 : 32'd1);
    chk("issue_busy", 32'(ifa.busy), 32'd1);
    @(negedge clk);
    chk("done_bus_enable", 32'(ifa.mem_bus_enable), 32'd0);
    chk("done_write_enable", 32'(ifa.mem_write_enable), 32'd0);
    chk("done_ack_onehot", 32'({ifa.ack1, ifa.ack0}), port ? 32'd2 : 32'd1);
    ifa.req0 = 1'b0;
    ifa.req1 = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   got;
    int   last;
    int   en_cnt;
    bit   done;
    checks = 0; failures = 0; cyc = 0; acks_rr = 0; acks_fp = 0;
    rst_n = 1'b0;
    ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0; ifa.addr0 = 0; ifa.addr1 = 0;
    ifa.wdata0 = 0; ifa.wdata1 = 0; ifa.mask0 = 0; ifa.mask1 = 0;
    ifp.req0 = 0; ifp.req1 = 0; ifp.we0 = 0; ifp.we1 = 0; ifp.addr0 = 0; ifp.addr1 = 0;
    ifp.wdata0 = 0; ifp.wdata1 = 0; ifp.mask0 = 0; ifp.mask1 = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_rr", 32'(rr_outs_any()), 32'd0);
    chk("reset_outputs_fp", 32'(fp_outs_any()), 32'd0);
    rst_n = 1'b1;

    // 1: read on port 0; 2: write on port 1
    access(1'b0, 1'b0, 16'h4000, 32'h0, 4'h0);
    access(1'b1, 1'b1, 16'h8002, 32'hbeef_0000, 4'b0011);

    // 3: round-robin contention, six transactions starting with port 0
    @(negedge clk);
    ifa.addr0 = 16'h1000; ifa.addr1 = 16'h2000; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e.port = 1'(i % 2); e.chk_rd = 1'b1; e.rdata = mem_model((i % 2) ? 16'h2000 : 16'h1000);
      q_rr.push_back(e);
    end
    got = 0; last = 0; done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (ifa.ack0 || ifa.ack1) begin
        if (got > 0) chk("rr_ack_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        got++;
        if (got == 6) begin
          ifa.req0 = 1'b0; ifa.req1 = 1'b0; done = 1;
        end
      end
    end
    if (!done) chk("rr_contention_timeout", 32'(got), 32'd6);
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;

    // 4: fixed priority, port 0 always wins
    @(negedge clk);
    ifp.addr0 = 16'h0100; ifp.addr1 = 16'h0200; ifp.req0 = 1'b1; ifp.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.port = 1'b0; e.chk_rd = 1'b1; e.rdata = mem_model(16'h0100);
      q_fp.push_back(e);
    end
    got = 0; done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (ifp.ack0 || ifp.ack1) begin
        got++;
        if (got == 4) begin
          ifp.req0 = 1'b0; ifp.req1 = 1'b0; done = 1;
        end
      end
    end
    if (!done) chk("fp_contention_timeout", 32'(got), 32'd4);
    ifp.req0 = 1'b0; ifp.req1 = 1'b0;

    // 5: reset during ISSUE of a port-0 access, no ack expected
    @(negedge clk);
    ifa.we0 = 1'b0; ifa.addr0 = 16'h3000; ifa.req0 = 1'b1;
    @(negedge clk);
    chk("pre_reset_bus_enable", 32'(ifa.mem_bus_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(rr_outs_any()), 32'd0);
    ifa.req0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_reset_outputs", 32'(rr_outs_any()), 32'd0);
    rst_n = 1'b1;
    ifa.addr0 = 16'h0010; ifa.addr1 = 16'h0020; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    e.port = 1'b0; e.chk_rd = 1'b1; e.rdata = mem_model(16'h0010); q_rr.push_back(e);
    e.port = 1'b1; e.chk_rd = 1'b1; e.rdata = mem_model(16'h0020); q_rr.push_back(e);
    got = 0; done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (ifa.ack0 || ifa.ack1) begin
        got++;
        if (got == 2) begin
          ifa.req0 = 1'b0; ifa.req1 = 1'b0; done = 1;
        end
      end
    end
    if (!done) chk("post_reset_timeout", 32'(got), 32'd2);
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;

    // 6: back-to-back on port 0, enable period of 3 cycles
    @(negedge clk);
    ifa.addr0 = 16'h0040; ifa.req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.port = 1'b0; e.chk_rd = 1'b1; e.rdata = mem_model(16'h0040); q_rr.push_back(e);
    end
    got = 0; last = 0; en_cnt = 0; done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (ifa.mem_bus_enable) begin
        if (en_cnt > 0) chk("b2b_enable_period", 32'(cyc - last), 32'd3);
        last = cyc;
        en_cnt++;
      end
      if (ifa.ack0) begin
        got++;
        if (got == 3) begin
          ifa.req0 = 1'b0; done = 1;
        end
      end
    end
    if (!done) chk("b2b_timeout", 32'(got), 32'd3);
    ifa.req0 = 1'b0;
    en_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifa.mem_bus_enable || ifp.mem_bus_enable) en_cnt++;
    end
    chk("idle_no_enables", 32'(en_cnt), 32'd0);

    chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
    chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);
    chk("rr_total_acks", 32'(acks_rr), 32'd13);
    chk("fp_total_acks", 32'(acks_fp), 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
